// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, write-back, flags and issue signals of the register file
interface regfile_mp_if #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int NREAD = 2,
    parameter int FW    = 16
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;
    logic [NREAD-1:0]       rd_en;
    logic [NREAD*AW-1:0]    rd_addr;
    logic [WIDTH-1:0]       r_pc;
    logic [NREAD*WIDTH-1:0] rd_data;
    logic                   w0_en;
    logic [AW-1:0]          w0_addr;
    logic [WIDTH-1:0]       w0_data;
    logic                   w0_flags_en;
    logic [FW-1:0]          w0_flags;
    logic                   w1_en;
    logic [AW-1:0]          w1_addr;
    logic [WIDTH-1:0]       w1_data;
    logic                   w1_flags_en;
    logic [FW-1:0]          w1_flags;
    logic                   iss_en;
    logic [AW-1:0]          iss_addr;
    logic [FW-1:0]          flags;
    logic [NREGS-1:0]       busy;
    modport master (
        output rd_en, rd_addr, r_pc, w0_en, w0_addr, w0_data, w0_flags_en, w0_flags,
               w1_en, w1_addr, w1_data, w1_flags_en, w1_flags, iss_en, iss_addr,
        input  rd_data, flags, busy
    );
    modport slave (
        input  rd_en, rd_addr, r_pc, w0_en, w0_addr, w0_data, w0_flags_en, w0_flags,
               w1_en, w1_addr, w1_data, w1_flags_en, w1_flags, iss_en, iss_addr,
        output rd_data, flags, busy
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read register file with two forwarded write ports, flags and busy scoreboard
module regfile_mp #(
    parameter int WIDTH    = 16,
    parameter int NREGS    = 8,
    parameter int NREAD    = 2,
    parameter int PC_INDEX = 3,
    parameter int FW       = 16
) (
    input logic         clk,
    input logic         rst,
    regfile_mp_if.slave rf_if
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;
    logic [WIDTH-1:0]       regs_q [NREGS];
    logic [WIDTH-1:0]       regs_d [NREGS];
    logic [NREAD*WIDTH-1:0] rd_data_q, rd_data_d;
    logic [FW-1:0]          flags_q, flags_d;
    logic [NREGS-1:0]       busy_q, busy_d;
    // post-write register image (w1 over w0, PC slot pinned to 0); reads use it for forwarding
    always_comb begin
        for (int r = 0; r < NREGS; r++)
            regs_d[r] = (r == PC_INDEX) ? '0 :
                        (rf_if.w1_en && int'(rf_if.w1_addr) == r) ? rf_if.w1_data :
                        (rf_if.w0_en && int'(rf_if.w0_addr) == r) ? rf_if.w0_data : regs_q[r];
    end
    // per-port read: PC pseudo-register first, otherwise the post-write image
    always_comb begin
        for (int i = 0; i < NREAD; i++)
            rd_data_d[i*WIDTH +: WIDTH] = !rf_if.rd_en[i] ? rd_data_q[i*WIDTH +: WIDTH] :
                (int'(rf_if.rd_addr[i*AW +: AW]) == PC_INDEX) ? rf_if.r_pc :
                regs_d[rf_if.rd_addr[i*AW +: AW]];
    end
    // flags source priority and scoreboard clear-then-set
    always_comb begin
        flags_d = rf_if.w1_flags_en ? rf_if.w1_flags : rf_if.w0_flags_en ? rf_if.w0_flags : flags_q;
        busy_d = busy_q;
        if (rf_if.w0_en) busy_d[rf_if.w0_addr] = 1'b0;
        if (rf_if.w1_en) busy_d[rf_if.w1_addr] = 1'b0;
        if (rf_if.iss_en) busy_d[rf_if.iss_addr] = 1'b1;
        busy_d[PC_INDEX] = 1'b0;
    end
    // state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q    <= '{default: '0};
            rd_data_q <= '0;
            flags_q   <= '0;
            busy_q    <= '0;
        end else begin
            regs_q    <= regs_d;
            rd_data_q <= rd_data_d;
            flags_q   <= flags_d;
            busy_q    <= busy_d;
        end
    end
    assign rf_if.rd_data = rd_data_q;
    assign rf_if.flags   = flags_q;
    assign rf_if.busy    = busy_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed plus randomized checks against an array-based reference model
module tb_regfile_mp;
    localparam int PC = 3;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_pass = 0;
    logic [15:0] m_regs [8];
    logic [15:0] m_rd [2];
    logic [15:0] m_flags;
    logic [7:0]  m_busy;

    regfile_mp_if #(.WIDTH(16), .NREGS(8), .NREAD(2), .FW(16)) bus ();
    regfile_mp #(.WIDTH(16), .NREGS(8), .NREAD(2), .PC_INDEX(PC), .FW(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .rf_if(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic idle();
        rst = 1'b0;
        bus.rd_en = '0; bus.rd_addr = '0; bus.r_pc = '0;
        bus.w0_en = 1'b0; bus.w0_addr = '0; bus.w0_data = '0; bus.w0_flags_en = 1'b0; bus.w0_flags = '0;
        bus.w1_en = 1'b0; bus.w1_addr = '0; bus.w1_data = '0; bus.w1_flags_en = 1'b0; bus.w1_flags = '0;
        bus.iss_en = 1'b0; bus.iss_addr = '0;
    endtask

    // one clock: advance the model from the spec rules, then compare every output
    task automatic step();
        logic [15:0] nr [8];
        @(posedge clk);
        if (rst) begin
            m_regs = '{default: '0};
            m_rd = '{default: '0};
            m_flags = '0;
            m_busy = '0;
        end else begin
            nr = m_regs;
            if (bus.w0_en && int'(bus.w0_addr) != PC) nr[bus.w0_addr] = bus.w0_data;
            if (bus.w1_en && int'(bus.w1_addr) != PC) nr[bus.w1_addr] = bus.w1_data;
            for (int i = 0; i < 2; i++)
                if (bus.rd_en[i]) begin
                    logic [2:0] a;
                    a = bus.rd_addr[i*3 +: 3];
                    m_rd[i] = (int'(a) == PC) ? bus.r_pc : nr[a];
                end
            if (bus.w1_flags_en) m_flags = bus.w1_flags;
            else if (bus.w0_flags_en) m_flags = bus.w0_flags;
            if (bus.w0_en) m_busy[bus.w0_addr] = 1'b0;
            if (bus.w1_en) m_busy[bus.w1_addr] = 1'b0;
            if (bus.iss_en && int'(bus.iss_addr) != PC) m_busy[bus.iss_addr] = 1'b1;
            m_regs = nr;
        end
        #1;
        chk("rd_data", 64'(bus.rd_data), 64'({m_rd[1], m_rd[0]}));
        chk("flags", 64'(bus.flags), 64'(m_flags));
        chk("busy", 64'(bus.busy), 64'(m_busy));
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1; bus.rd_en = 2'b11; bus.rd_addr = {3'd5, 3'd0};
        bus.w0_en = 1'b1; bus.w0_addr = 3'd5; bus.w0_data = 16'hDEAD; bus.iss_en = 1'b1; bus.iss_addr = 3'd1;
        step();
        chk("reset_rd", 64'(bus.rd_data), 64'h0);
        chk("reset_busy", 64'(bus.busy), 64'h0);
        bus.rd_en = 2'b11; bus.rd_addr = {3'd5, 3'd0};
        step();
        chk("reset_regs", 64'(bus.rd_data), 64'h0);

        bus.w0_en = 1'b1; bus.w0_addr = 3'd2; bus.w0_data = 16'h1234;
        step();
        bus.rd_en = 2'b01; bus.rd_addr = {3'd0, 3'd2};
        step();
        chk("wr_readback", 64'(bus.rd_data[15:0]), 64'h1234);

        bus.w0_en = 1'b1; bus.w0_addr = 3'd4; bus.w0_data = 16'hAAAA;
        bus.w1_en = 1'b1; bus.w1_addr = 3'd4; bus.w1_data = 16'h5555;
        bus.rd_en = 2'b01; bus.rd_addr = {3'd0, 3'd4};
        step();
        chk("fwd_w1_wins", 64'(bus.rd_data[15:0]), 64'h5555);
        bus.rd_en = 2'b10; bus.rd_addr = {3'd4, 3'd0};
        step();
        chk("stored_w1_wins", 64'(bus.rd_data[31:16]), 64'h5555);

        bus.r_pc = 16'hC000; bus.w0_en = 1'b1; bus.w0_addr = 3'd3; bus.w0_data = 16'hFFFF;
        bus.rd_en = 2'b11; bus.rd_addr = {3'd3, 3'd3}; bus.iss_en = 1'b1; bus.iss_addr = 3'd3;
        step();
        chk("pc_read", 64'(bus.rd_data), 64'hC000_C000);
        chk("pc_busy", 64'(bus.busy[3]), 64'h0);

        bus.w0_flags_en = 1'b1; bus.w0_flags = 16'h0001; bus.w1_flags_en = 1'b1; bus.w1_flags = 16'h0080;
        step();
        chk("flags_w1", 64'(bus.flags), 64'h0080);
        bus.w0_flags_en = 1'b1; bus.w0_flags = 16'h0001; bus.w1_flags = 16'h0080;
        step();
        chk("flags_w0", 64'(bus.flags), 64'h0001);
        bus.w0_flags = 16'hFFFF; bus.w1_flags = 16'hFFFF;
        step();
        chk("flags_hold", 64'(bus.flags), 64'h0001);

        bus.iss_en = 1'b1; bus.iss_addr = 3'd1;
        step();
        chk("busy_set", 64'(bus.busy), 64'h02);
        bus.w0_en = 1'b1; bus.w0_addr = 3'd1; bus.iss_en = 1'b1; bus.iss_addr = 3'd1;
        step();
        chk("busy_set_wins", 64'(bus.busy), 64'h02);
        bus.w1_en = 1'b1; bus.w1_addr = 3'd1;
        step();
        chk("busy_clear", 64'(bus.busy), 64'h00);
        foreach (m_rd[k]) begin end
        for (int b = 0; b < 8; b++) begin
            if (b == 0 || b == 3) continue;
            bus.iss_en = 1'b1; bus.iss_addr = 3'(b);
            step();
        end
        chk("busy_f6", 64'(bus.busy), 64'hF6);
        rst = 1'b1;
        step();
        chk("busy_rst", 64'(bus.busy), 64'h00);

        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            bus.rd_en = 2'($urandom); bus.rd_addr = 6'($urandom); bus.r_pc = 16'($urandom);
            bus.w0_en = 1'($urandom); bus.w0_addr = 3'($urandom); bus.w0_data = 16'($urandom);
            bus.w0_flags_en = 1'($urandom); bus.w0_flags = 16'($urandom);
            bus.w1_en = 1'($urandom); bus.w1_addr = 3'($urandom); bus.w1_data = 16'($urandom);
            bus.w1_flags_en = 1'($urandom); bus.w1_flags = 16'($urandom);
            bus.iss_en = 1'($urandom); bus.iss_addr = 3'($urandom);
            step();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor of the core register file: configurable data width, register count and number of read ports.
- Two write-back ports (ALU and RMW/load) with priority resolution, write-to-read forwarding and a PC pseudo-register.
- Status-flags register with source priority, plus a per-register busy scoreboard used by the reservation station for issue gating.
- Sits between the reservation station (read side), the ALU/RMW units (write side) and instruction decode (flags, busy).

Parameters:
- WIDTH, 16, data width of registers and read/write data.
- NREGS, 8, number of architectural registers (power of 2, ≥2); AW = clog2(NREGS).
- NREAD, 2, number of read ports.
- PC_INDEX, 3, register index that reads as r_pc; writes to it are discarded.
- FW, 16, flags width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_en  in  NREAD  per-port read enable.
- rd_addr  in  NREAD*AW  packed read addresses; port i at bits [i*AW +: AW].
- r_pc  in  WIDTH  current PC value, returned for PC_INDEX reads.
- rd_data  out  NREAD*WIDTH  packed registered read data.
- w0_en  in  1  ALU write-back enable.
- w0_addr  in  AW  ALU write address.
- w0_data  in  WIDTH  ALU result.
- w0_flags_en  in  1  ALU flags write.
- w0_flags  in  FW  ALU flags.
- w1_en  in  1  RMW/load write-back enable.
- w1_addr  in  AW  RMW write address.
- w1_data  in  WIDTH  RMW result.
- w1_flags_en  in  1  RMW flags write.
- w1_flags  in  FW  RMW flags.
- iss_en  in  1  issue: mark iss_addr busy.
- iss_addr  in  AW  destination of issued instruction.
- flags  out  FW  registered flags.
- busy  out  NREGS  registered scoreboard vector.

Behaviour:
- Reset, while rst=1 at an edge:
  - all registers, rd_data, flags and busy go to 0.
  - Writes, issues and reads presented in that cycle are ignored.
  - Reset mid-operation discards pending busy state.
- Read latency is 1 cycle. On an edge with rd_en[i]=1, rd_data[i] loads, in priority order:
  - r_pc if addr==PC_INDEX;
  - else w1_data if w1_en and w1_addr==addr;
  - else w0_data if w0_en and w0_addr==addr;
  - else the stored register.
- With rd_en[i]=0, rd_data[i] holds its value. Ports are independent; any ports may read the same address.
- Register write on each edge:
  - w0_en writes w0_data to w0_addr; w1_en writes w1_data to w1_addr.
  - If both target the same address, w1 wins.
  - Writes to PC_INDEX are dropped; the stored value there stays 0.
- Flags: w1_flags_en=1 loads w1_flags (regardless of w0); else w0_flags_en=1 loads w0_flags; else hold.
- Scoreboard:
  - Each edge, busy[w0_addr] clears if w0_en and busy[w1_addr] clears if w1_en; iss_en then sets busy[iss_addr]. Set beats clear on the same index.
  - iss_addr==PC_INDEX is ignored; busy[PC_INDEX] is always 0.
  - Clearing an already-clear bit is harmless.
- Address widths are exact (AW bits), so no out-of-range indices exist.
- Forwarding yields the value visible after the concurrent write, so a read never returns stale data.

Test Plan:
- Reset then read: rst 1 cycle, rd_en=2'b11, addr0=0, addr1=5 -> next cycle rd_data both 0, flags=0, busy=0.
- Write/read-back: w0 writes 16'h1234 to r2; next cycle read r2 -> 16'h1234 after 1-cycle latency.
- Forwarding priority: same cycle w0 (r4, 16'hAAAA), w1 (r4, 16'h5555) and read r4 -> rd_data=16'h5555; a later read of r4 also returns 16'h5555.
- PC handling: r_pc=16'hC000, w0 writes 16'hFFFF to r3, read r3 on both ports -> both 16'hC000; busy[3] stays 0 after iss_en at addr 3.
- Flags priority: w0_flags=16'h0001 with w1_flags=16'h0080, both enabled -> flags=16'h0080; next cycle only w0 enabled -> 16'h0001; none enabled -> holds.
- Scoreboard: iss r1 -> busy=8'h02; next cycle w0 r1 plus iss r1 -> busy stays 8'h02; next cycle w1 r1 only -> 8'h00; rst while busy=8'hF6 -> 8'h00 (PC_INDEX=3).
